game_sequencer: RTL

Top-level game controller for the LED-matrix rhythm game. It debounces the three player buttons and sequences the play flow: menu with song select, countdown, play, pause, then result. It drives the scene select for the matrix driver, the song-select and load/enable for the note shifter, and the clear for the score counter. It replaces the ad-hoc button-state logic and is clocked by the system clock. Beat timing comes from a one-cycle tick input driven by the clock divider.

---
 rtl/game_pkg.sv | 19 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/game_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the rhythm game: scene select, song ids and sequencer states.
// The matrix driver and note shifter import the same scene/song values.
package game_pkg;

    localparam logic [1:0] SCENE_MENU   = 2'd0;
    localparam logic [1:0] SCENE_PLAY   = 2'd1;
    localparam logic [1:0] SCENE_RESULT = 2'd2;

    localparam logic [1:0] SONG_NONE    = 2'd0;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_COUNT,
        ST_PLAY,
        ST_PAUSE,
        ST_RESULT
    } fsm_t;

endpackage

// File: rtl/btn_debounce.sv
// One player button: 2-flop synchronizer, counter debounce, and a one-cycle press pulse
// registered one cycle after the debounced level rises.
module btn_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            // Any cycle of agreement restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Rhythm game play-flow controller: menu/song select, countdown, play, pause, result.
// Drives scene select, shifter load/enable and score clear from debounced button presses.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_SONGS    = 3,
    parameter int DEB_CYCLES   = 250000,
    parameter int COUNT_TICKS  = 3,
    parameter int RESULT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red_button,
    input  logic       blue_button,
    input  logic       yellow_button,
    input  logic       tick,
    input  logic       finish,
    output logic [1:0] state,
    output logic [1:0] song_sel,
    output logic [1:0] song_confirm,
    output logic       shift_load,
    output logic       shift_en,
    output logic       score_clr,
    output logic [1:0] countdown,
    output logic       paused
);

    localparam int            HW       = $clog2(RESULT_TICKS + 1);
    localparam logic [1:0]    SEL_MAX  = 2'(NUM_SONGS - 1);
    localparam logic [1:0]    CD_INIT  = 2'(COUNT_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RESULT_TICKS);

    logic [2:0] raw;
    logic [2:0] press;
    // Debounced levels stay available on the debouncer; the flow only needs press edges.
    logic [2:0] unused_level;

    assign raw = {yellow_button, blue_button, red_button};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(unused_level[i]),
            .press(press[i])
        );
    end

    logic red_p, blue_p, yel_p;
    assign red_p  = press[0];
    assign blue_p = press[1];
    assign yel_p  = press[2];

    fsm_t          fsm;
    logic [HW-1:0] hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm          <= ST_MENU;
            hold         <= '0;
            state        <= SCENE_MENU;
            song_sel     <= 2'd0;
            song_confirm <= SONG_NONE;
            shift_load   <= 1'b0;
            shift_en     <= 1'b0;
            score_clr    <= 1'b0;
            countdown    <= 2'd0;
            paused       <= 1'b0;
        end else begin
            shift_load <= 1'b0;
            score_clr  <= 1'b0;
            case (fsm)
                ST_MENU: begin
                    if (yel_p) begin
                        fsm          <= ST_COUNT;
                        state        <= SCENE_PLAY;
                        song_confirm <= song_sel + 2'd1;
                        shift_load   <= 1'b1;
                        score_clr    <= 1'b1;
                        countdown    <= CD_INIT;
                    end else if (red_p && !blue_p) begin
                        song_sel <= (song_sel == 2'd0) ? SEL_MAX : song_sel - 2'd1;
                    end else if (blue_p && !red_p) begin
                        song_sel <= (song_sel == SEL_MAX) ? 2'd0 : song_sel + 2'd1;
                    end
                end
                ST_COUNT: begin
                    if (tick) begin
                        if (countdown <= 2'd1) begin
                            fsm       <= ST_PLAY;
                            countdown <= 2'd0;
                            shift_en  <= 1'b1;
                        end else begin
                            countdown <= countdown - 2'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (finish) begin
                        fsm      <= ST_RESULT;
                        state    <= SCENE_RESULT;
                        shift_en <= 1'b0;
                    end else if (yel_p) begin
                        fsm      <= ST_PAUSE;
                        shift_en <= 1'b0;
                        paused   <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (yel_p) begin
                        fsm      <= ST_PLAY;
                        shift_en <= 1'b1;
                        paused   <= 1'b0;
                    end else if (red_p && blue_p) begin
                        fsm          <= ST_MENU;
                        state        <= SCENE_MENU;
                        song_confirm <= SONG_NONE;
                        paused       <= 1'b0;
                    end
                end
                ST_RESULT: begin
                    if (tick && hold != HOLD_MAX) hold <= hold + 1'b1;
                    if (yel_p && hold == HOLD_MAX) begin
                        fsm          <= ST_MENU;
                        state        <= SCENE_MENU;
                        song_confirm <= SONG_NONE;
                        hold         <= '0;
                    end
                end
                default: fsm <= ST_MENU;
            endcase
        end
    end

endmodule
